lot_sensor_driver: RTL

LOT_SENSOR_DRIVER -- requirements
Module: lot_sensor_driver

---
 rtl/lot_sensor_driver_if.sv | 23 ++
 rtl/lot_sensor_driver.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/lot_sensor_driver_if.sv
// rtl/lot_sensor_driver_if.sv - request/waveform bundle for the parking-lot sensor emulator
interface lot_sensor_driver_if #(
   parameter int HOLD_W = 8
);
   logic              req_valid;
   logic              req_ready;
   logic [1:0]        req_kind;
   logic [HOLD_W-1:0] hold;
   logic [1:0]        ab;
   logic              busy;
   logic              done;
   logic              err;

   modport master (
      output req_valid, req_kind, hold,
      input  req_ready, ab, busy, done, err
   );

   modport slave (
      input  req_valid, req_kind, hold,
      output req_ready, ab, busy, done, err
   );
endinterface

// File: rtl/lot_sensor_driver.sv
// rtl/lot_sensor_driver.sv - emulates an a/b beam-sensor pair for enter/exit/pedestrian passes
// Optional pedestrian waveform is enabled with macro LOT_SENSOR_PED_EN.
module lot_sensor_driver #(
   parameter int HOLD_W = 8,
   parameter int GAP    = 2
) (
   input logic               clk,
   input logic               reset,
   lot_sensor_driver_if.slave bus
);

   typedef enum logic [2:0] {IDLE, PH1, PH2, PH3, QUIET} state_t;

   localparam logic [1:0] K_ENTER = 2'b00;
   localparam logic [1:0] K_EXIT  = 2'b01;
   localparam logic [1:0] K_PED   = 2'b10;
   localparam logic [3:0] GAP_M1  = 4'(GAP - 1);

   state_t            state;
   logic [1:0]        kind_q;
   logic [HOLD_W-1:0] hm1_q;
   logic [HOLD_W-1:0] cnt;
   logic [3:0]        gcnt;
   logic [1:0]        ab_q;
   logic              busy_q;
   logic              done_q;
   logic              err_q;
   logic              ready_q;
   logic              kind_ok;
   logic [HOLD_W-1:0] hold_m1;

   // Counting down from H-1 keeps hold = 2^HOLD_W-1 inside HOLD_W bits.
   assign hold_m1 = (bus.hold == '0) ? '0 : bus.hold - HOLD_W'(1);

`ifdef LOT_SENSOR_PED_EN
   assign kind_ok = (bus.req_kind != 2'b11);
`else
   assign kind_ok = (bus.req_kind[1] == 1'b0);
`endif

   function automatic logic [1:0] phase_ab(input logic [1:0] kind, input state_t ph);
      logic [1:0] v;
      v = 2'b00;
      case (kind)
         K_ENTER: begin
            case (ph)
               PH1:     v = 2'b10;
               PH2:     v = 2'b11;
               PH3:     v = 2'b01;
               default: v = 2'b00;
            endcase
         end
         K_EXIT: begin
            case (ph)
               PH1:     v = 2'b01;
               PH2:     v = 2'b11;
               PH3:     v = 2'b10;
               default: v = 2'b00;
            endcase
         end
         default: begin
            case (ph)
               PH1:     v = 2'b11;
               PH2:     v = 2'b10;
               default: v = 2'b00;
            endcase
         end
      endcase
      return v;
   endfunction

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         kind_q  <= 2'b00;
         hm1_q   <= '0;
         cnt     <= '0;
         gcnt    <= '0;
         ab_q    <= 2'b00;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         ready_q <= 1'b1;
      end else begin
         done_q <= 1'b0;
         err_q  <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.req_valid && ready_q) begin
                  if (kind_ok) begin
                     kind_q  <= bus.req_kind;
                     hm1_q   <= hold_m1;
                     cnt     <= hold_m1;
                     state   <= PH1;
                     ab_q    <= phase_ab(bus.req_kind, PH1);
                     busy_q  <= 1'b1;
                     ready_q <= 1'b0;
                  end else begin
                     err_q <= 1'b1;
                  end
               end
            end
            PH1: begin
               if (cnt == '0) begin
                  cnt   <= hm1_q;
                  state <= PH2;
                  ab_q  <= phase_ab(kind_q, PH2);
               end else begin
                  cnt <= cnt - HOLD_W'(1);
               end
            end
            PH2: begin
               if (cnt == '0) begin
                  // Pedestrian passes have only two phases.
                  if (kind_q == K_PED) begin
                     state  <= QUIET;
                     ab_q   <= 2'b00;
                     done_q <= 1'b1;
                     gcnt   <= GAP_M1;
                  end else begin
                     cnt   <= hm1_q;
                     state <= PH3;
                     ab_q  <= phase_ab(kind_q, PH3);
                  end
               end else begin
                  cnt <= cnt - HOLD_W'(1);
               end
            end
            PH3: begin
               if (cnt == '0) begin
                  state  <= QUIET;
                  ab_q   <= 2'b00;
                  done_q <= 1'b1;
                  gcnt   <= GAP_M1;
               end else begin
                  cnt <= cnt - HOLD_W'(1);
               end
            end
            QUIET: begin
               if (gcnt == 4'd0) begin
                  state   <= IDLE;
                  busy_q  <= 1'b0;
                  ready_q <= 1'b1;
               end else begin
                  gcnt <= gcnt - 4'd1;
               end
            end
            default: begin
               state   <= IDLE;
               ab_q    <= 2'b00;
               busy_q  <= 1'b0;
               ready_q <= 1'b1;
            end
         endcase
      end
   end

   assign bus.ab        = ab_q;
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.err       = err_q;
   assign bus.req_ready = ready_q;

endmodule
